hs32_sram_ctl: RTL

//  Bus responder for the CPU external memory interface (addr/rw/dout/valid -> din/done).

---
 rtl/hs32_sram_ctl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/hs32_sram_ctl.sv
// rtl/hs32_sram_ctl.sv - CPU bus responder serving 32-bit requests as two 16-bit async SRAM accesses.
// Optional HS32_SRAM_BUSERR_EN adds berr for addresses beyond the SRAM window.
module hs32_sram_ctl #(
    parameter int AW   = 17,
    parameter int WAIT = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   addr,
    input  logic          rw,
    input  logic [31:0]   din,
    output logic [31:0]   dout,
    input  logic          valid,
    output logic          done,
    output logic [AW-1:0] sram_addr,
    input  logic [15:0]   sram_dq_i,
    output logic [15:0]   sram_dq_o,
    output logic          sram_dq_oe,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n
`ifdef HS32_SRAM_BUSERR_EN
    ,
    output logic          berr
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          setup_q, setup_d;
    logic          rw_q, rw_d;
    logic [AW-2:0] base_q, base_d;
    logic [15:0]   din_hi_q, din_hi_d;
    logic [31:0]   dout_q, dout_d;
    logic          done_q, done_d;
    logic [AW-1:0] sram_addr_q, sram_addr_d;
    logic [15:0]   dq_o_q, dq_o_d;
    logic          dq_oe_q, dq_oe_d;
    logic          ce_n_q, ce_n_d;
    logic          oe_n_q, oe_n_d;
    logic          we_n_q, we_n_d;
    logic          berr_q, berr_d;
    logic          addr_oob;
    logic          phase_last;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{addr[1:0], addr[31:AW+1]};

`ifdef HS32_SRAM_BUSERR_EN
    assign addr_oob = |addr[31:AW+1];
    assign berr     = berr_q;
`else
    assign addr_oob = 1'b0;
    logic unused_berr;
    assign unused_berr = berr_q;
`endif

    // A write phase spends its first cycle in address setup before the counted strobe cycles.
    assign phase_last = (cnt_q == 4'd0) && !setup_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        setup_d     = setup_q;
        rw_d        = rw_q;
        base_d      = base_q;
        din_hi_d    = din_hi_q;
        dout_d      = dout_q;
        done_d      = 1'b0;
        sram_addr_d = sram_addr_q;
        dq_o_d      = dq_o_q;
        dq_oe_d     = 1'b0;
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        berr_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    rw_d     = rw;
                    base_d   = addr[AW:2];
                    din_hi_d = din[31:16];
                    if (addr_oob) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        dout_d  = 32'h0;
                        berr_d  = 1'b1;
                    end else begin
                        state_d     = S_LO;
                        cnt_d       = WAIT_CNT;
                        setup_d     = rw;
                        ce_n_d      = 1'b0;
                        oe_n_d      = rw;
                        dq_oe_d     = rw;
                        sram_addr_d = {addr[AW:2], 1'b0};
                        if (rw) begin
                            dq_o_d = din[15:0];
                        end
                    end
                end
            end
            S_LO, S_HI: begin
                if (!phase_last) begin
                    ce_n_d  = 1'b0;
                    oe_n_d  = rw_q;
                    dq_oe_d = rw_q;
                    we_n_d  = !rw_q;
                    setup_d = 1'b0;
                    if (!setup_q) begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end else if (state_q == S_LO) begin
                    if (!rw_q) begin
                        dout_d[15:0] = sram_dq_i;
                    end
                    state_d     = S_HI;
                    cnt_d       = WAIT_CNT;
                    setup_d     = rw_q;
                    ce_n_d      = 1'b0;
                    oe_n_d      = rw_q;
                    dq_oe_d     = rw_q;
                    sram_addr_d = {base_q, 1'b1};
                    if (rw_q) begin
                        dq_o_d = din_hi_q;
                    end
                end else begin
                    if (!rw_q) begin
                        dout_d[31:16] = sram_dq_i;
                    end
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            setup_q     <= 1'b0;
            rw_q        <= 1'b0;
            base_q      <= '0;
            din_hi_q    <= 16'h0;
            dout_q      <= 32'h0;
            done_q      <= 1'b0;
            sram_addr_q <= '0;
            dq_o_q      <= 16'h0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            berr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            setup_q     <= setup_d;
            rw_q        <= rw_d;
            base_q      <= base_d;
            din_hi_q    <= din_hi_d;
            dout_q      <= dout_d;
            done_q      <= done_d;
            sram_addr_q <= sram_addr_d;
            dq_o_q      <= dq_o_d;
            dq_oe_q     <= dq_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            berr_q      <= berr_d;
        end
    end

    assign dout       = dout_q;
    assign done       = done_q;
    assign sram_addr  = sram_addr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;

endmodule
